conv_feed_ctrl: RTL

//  Sequences one convolution pass over a feature map held in a 1-cycle-latency read buffer.

---
 rtl/conv_feed_ctrl.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/conv_feed_ctrl.sv
// Convolution feed sequencer: walks (oy,ox,ky,kx), issues feature-map reads and emits MAC framing
// flags two cycles after each issue. Optional build macro CONV_FEED_STRIDE2_EN selects stride 2.
module conv_feed_ctrl #(
  parameter int IMG_W   = 8,
  parameter int IMG_H   = 8,
  parameter int K       = 3,
  parameter int ADDR_BW = 16,
  parameter int CNT_BW  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_start,
  input  logic               i_stall,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_fm_rd_en,
  output logic [ADDR_BW-1:0] o_fm_addr,
  output logic               o_tap_valid,
  output logic [CNT_BW-1:0]  o_k_idx,
  output logic               o_acc_first,
  output logic               o_acc_last,
  output logic [CNT_BW-1:0]  o_out_row,
  output logic [CNT_BW-1:0]  o_out_col
);

`ifdef CONV_FEED_STRIDE2_EN
  localparam int S = 2;
`else
  localparam int S = 1;
`endif
  localparam int OW = (IMG_W - K) / S + 1;
  localparam int OH = (IMG_H - K) / S + 1;
  localparam logic [CNT_BW-1:0]  KM1    = CNT_BW'(K - 1);
  localparam logic [CNT_BW-1:0]  KC     = CNT_BW'(K);
  localparam logic [CNT_BW-1:0]  STEP   = CNT_BW'(S);
  localparam logic [CNT_BW-1:0]  ONE    = CNT_BW'(1);
  localparam logic [CNT_BW-1:0]  OX_MAX = CNT_BW'((OW - 1) * S);
  localparam logic [CNT_BW-1:0]  OY_MAX = CNT_BW'((OH - 1) * S);
  localparam logic [ADDR_BW-1:0] ROW_W  = ADDR_BW'(IMG_W);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t              state_q;
  logic [CNT_BW-1:0]   kx_q, ky_q, ox_q, oy_q;
  logic [CNT_BW-1:0]   kx_d, ky_d, ox_d, oy_d;
  logic [ADDR_BW-1:0]  addr_d, addr_q;
  logic                fin_q, drain_q, busy_q, done_q, rd_en_q;
  logic                issue, last_tap;
  // stage 0 travels with the read strobe; stages 1 and 2 track the buffer and preprocessing registers
  logic                first0_q, last0_q, first1_q, last1_q, first2_q, last2_q, v1_q, v2_q;
  logic [CNT_BW-1:0]   k0_q, row0_q, col0_q, k1_q, row1_q, col1_q, k2_q, row2_q, col2_q;

  always_comb begin
    issue    = (state_q == RUN) && !fin_q && !i_stall;
    last_tap = (kx_q == KM1) && (ky_q == KM1) && (ox_q == OX_MAX) && (oy_q == OY_MAX);
    kx_d = kx_q;
    ky_d = ky_q;
    ox_d = ox_q;
    oy_d = oy_q;
    if (kx_q != KM1) begin
      kx_d = kx_q + ONE;
    end else begin
      kx_d = '0;
      if (ky_q != KM1) begin
        ky_d = ky_q + ONE;
      end else begin
        ky_d = '0;
        if (ox_q != OX_MAX) begin
          ox_d = ox_q + STEP;
        end else begin
          ox_d = '0;
          if (oy_q != OY_MAX) oy_d = oy_q + STEP;
        end
      end
    end
    addr_d = (ADDR_BW'(oy_q) + ADDR_BW'(ky_q)) * ROW_W + ADDR_BW'(ox_q) + ADDR_BW'(kx_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      kx_q     <= '0;
      ky_q     <= '0;
      ox_q     <= '0;
      oy_q     <= '0;
      addr_q   <= '0;
      fin_q    <= 1'b0;
      drain_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rd_en_q  <= 1'b0;
      first0_q <= 1'b0;
      last0_q  <= 1'b0;
      k0_q     <= '0;
      row0_q   <= '0;
      col0_q   <= '0;
      v1_q     <= 1'b0;
      first1_q <= 1'b0;
      last1_q  <= 1'b0;
      k1_q     <= '0;
      row1_q   <= '0;
      col1_q   <= '0;
      v2_q     <= 1'b0;
      first2_q <= 1'b0;
      last2_q  <= 1'b0;
      k2_q     <= '0;
      row2_q   <= '0;
      col2_q   <= '0;
    end else begin
      rd_en_q  <= issue;
      addr_q   <= issue ? addr_d : '0;
      first0_q <= issue && (ky_q == '0) && (kx_q == '0);
      last0_q  <= issue && (ky_q == KM1) && (kx_q == KM1);
      k0_q     <= issue ? ky_q * KC + kx_q : '0;
      row0_q   <= issue ? oy_q : '0;
      col0_q   <= issue ? ox_q : '0;
      if (issue) begin
        kx_q  <= kx_d;
        ky_q  <= ky_d;
        ox_q  <= ox_d;
        oy_q  <= oy_d;
        fin_q <= last_tap;
      end
      v1_q     <= rd_en_q;
      first1_q <= first0_q;
      last1_q  <= last0_q;
      k1_q     <= k0_q;
      row1_q   <= row0_q;
      col1_q   <= col0_q;
      v2_q     <= v1_q;
      first2_q <= first1_q;
      last2_q  <= last1_q;
      k2_q     <= k1_q;
      row2_q   <= row1_q;
      col2_q   <= col1_q;
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (i_start) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
            kx_q    <= '0;
            ky_q    <= '0;
            ox_q    <= '0;
            oy_q    <= '0;
            fin_q   <= 1'b0;
          end
        end
        RUN: begin
          if (fin_q) begin
            state_q <= DRAIN;
            drain_q <= 1'b0;
          end
        end
        DRAIN: begin
          drain_q <= 1'b1;
          if (drain_q) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_fm_rd_en  = rd_en_q;
  assign o_fm_addr   = addr_q;
  assign o_tap_valid = v2_q;
  assign o_k_idx     = k2_q;
  assign o_acc_first = first2_q;
  assign o_acc_last  = last2_q;
  assign o_out_row   = row2_q;
  assign o_out_col   = col2_q;

endmodule
